// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES ripple slices with registered inter-slice carries
module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int WS = WIDTH / STAGES;
   if (STAGES < 1 || STAGES > WIDTH || WIDTH < 2 || WIDTH % STAGES != 0) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES, with STAGES in 1..WIDTH");
   end
   genvar i;
   for (i = 0; i < STAGES; i++) begin : g_st
      localparam int LO = i * WS;
      localparam int HI = LO + WS;
      logic [WIDTH-1:LO] a_op, b_op;
      logic [HI-1:0]     s_nx, s_q;
      logic [WS:0]       sl;
      logic              c_op, v_op, c_q, v_q;
      if (i == 0) begin : g_head
         assign a_op = a;
         assign b_op = sub ? ~b : b;
         assign c_op = cin ^ sub;
         assign v_op = in_valid;
         assign s_nx = sl[WS-1:0];
      end else begin : g_body
         assign a_op = g_st[i-1].g_skew.a_q;
         assign b_op = g_st[i-1].g_skew.b_q;
         assign c_op = g_st[i-1].c_q;
         assign v_op = g_st[i-1].v_q;
         assign s_nx = {sl[WS-1:0], g_st[i-1].s_q};
      end
      assign sl = {1'b0, a_op[HI-1:LO]} + {1'b0, b_op[HI-1:LO]} + {{WS{1'b0}}, c_op};
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else if (en) begin
            s_q <= s_nx;
            c_q <= sl[WS];
            v_q <= v_op;
         end
      if (i < STAGES - 1) begin : g_skew
         logic [WIDTH-1:HI] a_q, b_q;
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= a_op[WIDTH-1:HI];
               b_q <= b_op[WIDTH-1:HI];
            end
      end else begin : g_tail
         // carry into the MSB is recovered from the MSB sum bit inside this slice's ripple
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               ovf  <= 1'b0;
               zero <= 1'b0;
            end else if (en) begin
               ovf  <= a_op[WIDTH-1] ^ b_op[WIDTH-1] ^ sl[WS-1] ^ sl[WS];
               zero <= ~|s_nx;
            end
      end
   end
   assign s         = g_st[STAGES-1].s_q;
   assign cout      = g_st[STAGES-1].c_q;
   assign out_valid = g_st[STAGES-1].v_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed checks of the 4-stage and 1-stage adder/subtractor
module tb_pipelined_addsub;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, sub = 1'b0, cin = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic out_valid, cout, ovf, zero, out_valid1, cout1, ovf1, zero1;
   logic [15:0] s, s1;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid), .s(s), .cout(cout), .ovf(ovf), .zero(zero));

   pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid1), .s(s1), .cout(cout1), .ovf(ovf1), .zero(zero1));

   task automatic set_op(input logic v, input logic [15:0] ta, input logic [15:0] tb, input logic ts, input logic tc);
      in_valid = v;
      a = ta;
      b = tb;
      sub = ts;
      cin = tc;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      en = 1'b1;
      set_op(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_chk++;
      if ({out_valid, cout, ovf, zero, s} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_state4: got %h want %h", {out_valid, cout, ovf, zero, s}, 20'h0);
      end
      n_chk++;
      if ({out_valid1, cout1, ovf1, zero1, s1} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_state1: got %h want %h", {out_valid1, cout1, ovf1, zero1, s1}, 20'h0);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_leak: out_valid got %b want 0", out_valid);
         end
      end
   endtask

   task automatic test_single_add;
      @(negedge clk);
      set_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_chk++;
         if (c == 4) begin
            if ({out_valid, cout, ovf, zero, s} !== {4'b1000, 16'h5555}) begin
               n_fail++;
               $display("FAIL single_add: got %h want %h", {out_valid, cout, ovf, zero, s}, {4'b1000, 16'h5555});
            end
         end else if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_add_valid c=%0d: got %b want 0", c, out_valid);
         end
      end
   endtask

   task automatic test_carry;
      logic [15:0] va [2] = '{16'hFFFF, 16'h7FFF};
      logic [15:0] vb [2] = '{16'h0000, 16'h0001};
      logic        vc [2] = '{1'b1, 1'b0};
      logic [19:0] ve [2] = '{{4'b1101, 16'h0000}, {4'b1010, 16'h8000}};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         set_op(1'b1, va[k], vb[k], 1'b0, vc[k]);
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 4) begin
               n_chk++;
               if ({out_valid, cout, ovf, zero, s} !== ve[k]) begin
                  n_fail++;
                  $display("FAIL carry_%0d: got %h want %h", k, {out_valid, cout, ovf, zero, s}, ve[k]);
               end
            end
         end
      end
   endtask

   task automatic test_sub;
      logic [15:0] va [2] = '{16'h0005, 16'h8000};
      logic [15:0] vb [2] = '{16'h0007, 16'h0001};
      logic [19:0] ve [2] = '{{4'b1000, 16'hFFFE}, {4'b1110, 16'h7FFF}};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         set_op(1'b1, va[k], vb[k], 1'b1, 1'b0);
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 4) begin
               n_chk++;
               if ({out_valid, cout, ovf, zero, s} !== ve[k]) begin
                  n_fail++;
                  $display("FAIL sub_%0d: got %h want %h", k, {out_valid, cout, ovf, zero, s}, ve[k]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic        sv [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] si [9] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      logic [15:0] se [9] = '{16'h0102, 16'h0204, 16'h0306, 16'h0000, 16'h0408, 16'h050A, 16'h060C, 16'h070E, 16'h0810};
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c >= 4 && c < 13) begin
            n_chk++;
            if (out_valid !== sv[c-4] || (sv[c-4] && s !== se[c-4])) begin
               n_fail++;
               $display("FAIL b2b_slot%0d: got v=%b s=%h want v=%b s=%h", c - 4, out_valid, s, sv[c-4], se[c-4]);
            end
         end else if (c > 0) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_idle c=%0d: got %b want 0", c, out_valid);
            end
         end
         if (c < 9) set_op(sv[c], si[c], si[c] * 16'h0101, 1'b0, 1'b0);
         else in_valid = 1'b0;
      end
   endtask

   task automatic test_stall;
      logic [19:0] ea = {4'b1000, 16'h3333};
      logic [19:0] eb = {4'b1100, 16'hEFFF};
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 8 || c >= 13) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_idle c=%0d: got %b want 0", c, out_valid);
            end
         end else if (c >= 9 && c <= 11) begin
            n_chk++;
            if ({out_valid, cout, ovf, zero, s} !== ea) begin
               n_fail++;
               $display("FAIL stall_res_a c=%0d: got %h want %h", c, {out_valid, cout, ovf, zero, s}, ea);
            end
         end else if (c == 12) begin
            n_chk++;
            if ({out_valid, cout, ovf, zero, s} !== eb) begin
               n_fail++;
               $display("FAIL stall_res_b: got %h want %h", {out_valid, cout, ovf, zero, s}, eb);
            end
         end
         if (c == 0) set_op(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
         else if (c == 1) set_op(1'b1, 16'hF000, 16'h0001, 1'b1, 1'b0);
         else if (c >= 3 && c <= 7 || c == 9 || c == 10) begin
            en = 1'b0;
            set_op(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
         end else begin
            en = 1'b1;
            in_valid = 1'b0;
         end
      end
      en = 1'b1;
   endtask

   task automatic test_mid_reset;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 4) begin
            n_chk++;
            if ({out_valid, cout, ovf, zero, s} !== {4'b1101, 16'h0000}) begin
               n_fail++;
               $display("FAIL pre_reset: got %h want %h", {out_valid, cout, ovf, zero, s}, {4'b1101, 16'h0000});
            end
         end
         if (c == 0) set_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
         else set_op(1'b1, 16'(c), 16'(c), 1'b0, 1'b0);
      end
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if ({out_valid, cout, ovf, zero, s} !== 20'h0) begin
         n_fail++;
         $display("FAIL async_reset4: got %h want %h", {out_valid, cout, ovf, zero, s}, 20'h0);
      end
      n_chk++;
      if (out_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset1: got %b want 0", out_valid1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_after_reset c=%0d: got %b%b want 00", c, out_valid, out_valid1);
         end
      end
   endtask

   task automatic test_stages1;
      @(negedge clk);
      set_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      n_chk++;
      if ({out_valid1, cout1, ovf1, zero1, s1} !== {4'b1000, 16'h5555}) begin
         n_fail++;
         $display("FAIL stages1_add: got %h want %h", {out_valid1, cout1, ovf1, zero1, s1}, {4'b1000, 16'h5555});
      end
      @(negedge clk);
      n_chk++;
      if (out_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL stages1_once: got %b want 0", out_valid1);
      end
   endtask

   initial begin
      test_reset;
      test_single_add;
      test_carry;
      test_sub;
      test_back_to_back;
      test_stall;
      test_mid_reset;
      test_stages1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor; successor to the team's 4-bit ripple adder.
- Splits the operand into STAGES equal slices. Each slice is ripple-added in one pipeline stage, and the carry is registered between stages.
- Adds add/subtract mode, carry-in, valid tracking, stall (enable) and flag outputs.
- Sits on ALU/datapath paths where a full-width ripple carry would not meet timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES and ≥ 2.
- STAGES, 4, number of pipeline stages = slices; must be in 1..WIDTH. Slice width W_S = WIDTH/STAGES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance; 0 holds every register (stall).
- in_valid  in  1  a, b, sub, cin carry a new operation this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B+cin; 1: A−B−cin, i.e. A + ~B + (1 ^ cin) (cin acts as borrow-in).
- cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  s and the flags hold a completed result.
- s  out  WIDTH  sum/difference.
- cout  out  1  add: carry out. Sub: NOT borrow, i.e. 1 when no borrow occurred.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  s == 0.

Behaviour:
- **Reset (async, rst=1):** all pipeline registers clear. out_valid=0, s=0, cout=0, ovf=0, zero=0. Applies immediately, mid-operation included. In-flight operations are discarded and never reappear.
- **Latency:** exactly STAGES cycles from an accepted input (in_valid & en at edge k) to outputs valid after edge k+STAGES−1+1, i.e. the output registers update on the STAGES-th enabled edge.
- **Throughput:** one operation per enabled cycle.
- **Stage i (0..STAGES−1):**
  - Adds slice i of A and slice i of B' (B' = sub ? ~B : B) plus the carry from stage i−1.
  - Stage 0's carry-in is cin ^ sub.
  - Result slice and carry are registered.
  - Slices of A and B' not yet consumed travel forward in skew registers. Completed sum slices travel forward in de-skew registers, so all WIDTH bits of s appear together.
  - The mode is captured at stage 0 (B inverted on entry). No later stage looks at sub.
- **Flags:**
  - ovf uses the carry into the MSB, taken inside the last stage's ripple.
  - zero is computed from the final registered s. It is registered alongside s, so it appears in the same cycle as s, with no extra latency.
- **Valid:**
  - A valid bit rides the pipeline with each operation.
  - Bubbles (in_valid=0 with en=1) propagate as out_valid=0.
  - Data registers for a bubble may update (don't-care), but out_valid must be 0.
- **Stall (en=0):**
  - Every register holds, including out_valid and the outputs.
  - in_valid is ignored; no operation is accepted.
  - Stall length is unbounded.
  - A stall and a reset in the same cycle: reset wins.
- **STAGES=1:** a single registered full-width ripple; latency 1.
- **Wrap-around:** the sum is modulo 2^WIDTH. Carry out appears only on cout and is never truncated silently.
- **Parameter checks:** an illegal parameter combination (WIDTH % STAGES ≠ 0) must stop elaboration via a generate-time error.

Test Plan:
1. **Reset then single add.** WIDTH=16, STAGES=4. Send a=0x1234, b=0x4321, sub=0, cin=0 with en=1 on one cycle, then in_valid=0.
   -> out_valid=1 for exactly one cycle, 4 cycles later, with s=0x5555, cout=0, ovf=0, zero=0.
2. **Full carry ripple across all slices.** a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, ovf=1, cout=0.
3. **Subtract.** a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0 (borrow). Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1, cout=1.
4. **Back-to-back stream.** 8 consecutive ops a=i, b=i·0x0101 (i=1..8), with a bubble after op 3 -> results appear in order, one per cycle, with a single out_valid=0 gap matching the bubble; each s = i + i·0x0101.
5. **Stall.** Launch 2 ops, drop en for 5 cycles mid-flight, then restore -> outputs frozen during the stall; both results appear correct, with total latency = 4 + 5 cycles.
6. **Mid-flight reset, then STAGES=1 re-elaboration.** Assert rst while 3 ops are in flight -> out_valid drops to 0 asynchronously, and no stale result appears after release. Re-elaborate with STAGES=1 and repeat test 1 -> result after 1 cycle.
